uart_dbg_rx: RTL and testbench
==============================

Name: uart_dbg_rx

Overview:
- UART receiver: the receive-side counterpart of the debug UART transmitter (8N1, LSB first, idle high).
- Samples the asynchronous rx pin, deserialises each frame and pushes the received bytes into an internal FIFO message queue.
- The consumer drains the queue through a first-word-fall-through read port.
- Sits in top next to the debug transmitter. Its typical use is host-to-FPGA debug commands, for example a redraw trigger or a status poll.

Parameters:
- SYS_CLK_FREQ, 12_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- MSG_QUEUE_SIZE, 8: FIFO depth in bytes. Must be a power of 2 and at least 2.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous reset, active-high.
- rx  in  1: asynchronous UART input, idle high.
- rd  in  1: pop the head byte. Ignored while empty=1.
- msg  out  8: head byte of the queue. Valid while empty=0; reads 8'h00 while empty=1.
- empty  out  1: queue holds no bytes.
- full  out  1: queue holds MSG_QUEUE_SIZE bytes.
- overflow  out  1: one-cycle pulse when a valid frame is dropped because the queue is full.
- frame_err  out  1: one-cycle pulse when the stop bit samples 0.

Behaviour:
- Clock and reset:
  - One clock domain, reset synchronous and active-high.
  - Reset values: empty=1, full=0, msg=8'h00, overflow=0, frame_err=0. FSM goes to IDLE, FIFO pointers and count go to 0, both rx synchroniser flops go to 1.
  - Reset mid-frame abandons the partial byte and all queued bytes.
- Bit timing:
  - CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE, integer division (104 at the defaults).
  - HALF_BIT = CLKS_PER_BIT / 2 (52).
  - A bit-timer counter of width clog2(CLKS_PER_BIT) counts clocks within each bit.
- Input synchroniser: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s=0, clear the timer and go to START.
  - START: after HALF_BIT clocks, sample rx_s.
    - Sample 0: reset the timer and bit index, go to DATA.
    - Sample 1: glitch or false start; go back to IDLE with no output.
  - DATA: every CLKS_PER_BIT clocks, shift rx_s into the MSB of a shift register (LSB-first reception). After bit index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - Sample 1: push the byte (if the queue is not full), go to IDLE.
    - Sample 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Latency:
  - Let T be the cycle on which the stop bit is sampled.
  - The FIFO write occurs at the edge ending T, so empty falls and msg is valid in cycle T+1.
  - overflow and frame_err are asserted during cycle T+1 for exactly one cycle.
- FIFO:
  - Circular buffer with read and write pointers of width log2(MSG_QUEUE_SIZE), wrapping modulo depth, plus a count register (width log2(MSG_QUEUE_SIZE)+1).
  - msg = mem[rd_ptr] when empty=0, else 8'h00.
  - A pop (rd=1 and empty=0) advances rd_ptr at the clock edge. The next byte appears on msg in the following cycle.
  - A push while full drops the byte, pulses overflow, and leaves FIFO contents unchanged.
  - Simultaneous push and pop while full: the pop frees a slot, the push is accepted, no overflow, count unchanged.
  - Simultaneous push and pop while empty: the pop is ignored, the push is accepted, count becomes 1.
- Outputs: empty and full are derived from count (count==0 and count==MSG_QUEUE_SIZE) and registered consistently with it. They are never both 1.
- Back-to-back frames: a start bit immediately after the stop bit (stop width exactly 1 bit) must be received correctly. The IDLE state checks rx_s in the cycle after STOP.

Test Plan:
- Send 8'hA5 (8N1, 104 clk/bit), rd=0 -> empty falls 1 cycle after the stop-bit sample; msg=8'hA5; frame_err=0; overflow=0.
- Glitch: hold rx low for 30 clocks, then high -> FSM returns to IDLE after START; empty stays 1; no pulses.
- Stop bit forced 0 when sending 8'h3C -> frame_err pulses exactly 1 cycle; empty stays 1; no byte is received until rx returns high and a new valid frame is sent.
- Send 9 bytes 8'h01..8'h09 back-to-back, rd=0 -> full=1 after the 8th; the 9th pulses overflow; popping 8 times yields 01..08 in order, then empty=1.
- Queue full with a 9th frame's stop sample coinciding with rd=1 -> no overflow; after draining, the pop sequence is 02..09.
- Assert reset while the 4th data bit of 8'hFF is being received, with 2 bytes queued -> next cycle empty=1, msg=8'h00; the next valid frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_dbg_rx.sv
// ============================================================================
// Module      : uart_dbg_rx
// Description : 8N1 UART receiver feeding a first-word-fall-through byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_dbg_rx #(
  parameter int SYS_CLK_FREQ   = 12_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int MSG_QUEUE_SIZE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] msg,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       frame_err
);

  localparam int c_CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
  localparam int c_TW           = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam int c_PW           = $clog2(MSG_QUEUE_SIZE);

  localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(c_HALF_BIT - 1);
  localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(c_CLKS_PER_BIT - 1);
  localparam logic [c_TW-1:0] c_TMR_ONE   = c_TW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
  localparam logic [c_PW:0]   c_CNT_ONE   = (c_PW+1)'(1);
  localparam logic [c_PW:0]   c_DEPTH     = (c_PW+1)'(MSG_QUEUE_SIZE);

  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_START     = 3'd1;
  localparam logic [2:0] c_S_DATA      = 3'd2;
  localparam logic [2:0] c_S_STOP      = 3'd3;
  localparam logic [2:0] c_S_WAIT_IDLE = 3'd4;

  logic            r_rx_meta;
  logic            r_rx_s;
  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_TW-1:0] r_timer;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;

  logic w_half_tick;
  logic w_bit_tick;
  logic w_timer_clr;
  logic w_shift_en;
  logic w_push;
  logic w_ferr;

  logic [7:0]    r_mem [MSG_QUEUE_SIZE];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW:0]   r_count;
  logic [c_PW:0]   w_count_nxt;
  logic            r_empty;
  logic            r_full;
  logic            r_overflow;
  logic            r_frame_err;
  logic            w_wr_en;
  logic            w_rd_en;

  // Both flops idle high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_half_tick = (r_timer == c_HALF_LAST);
  assign w_bit_tick  = (r_timer == c_BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:      if (!r_rx_s) w_state_nxt = c_S_START;
      c_S_START:     if (w_half_tick) w_state_nxt = r_rx_s ? c_S_IDLE : c_S_DATA;
      c_S_DATA:      if (w_bit_tick && (r_bit_idx == 3'd7)) w_state_nxt = c_S_STOP;
      c_S_STOP:      if (w_bit_tick) w_state_nxt = r_rx_s ? c_S_IDLE : c_S_WAIT_IDLE;
      c_S_WAIT_IDLE: if (r_rx_s) w_state_nxt = c_S_IDLE;
      default:       w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_timer_clr = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      c_S_IDLE:      w_timer_clr = 1'b1;
      c_S_START:     w_timer_clr = w_half_tick;
      c_S_DATA: begin
        w_timer_clr = w_bit_tick;
        w_shift_en  = w_bit_tick;
      end
      c_S_STOP: begin
        w_timer_clr = w_bit_tick;
        w_push      = w_bit_tick && r_rx_s;
        w_ferr      = w_bit_tick && !r_rx_s;
      end
      c_S_WAIT_IDLE: w_timer_clr = 1'b1;
      default:       w_timer_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_timer <= w_timer_clr ? '0 : r_timer + c_TMR_ONE;
      if (r_state != c_S_DATA) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // A pop in the same cycle frees the slot, so a full queue still accepts the push
  assign w_rd_en = rd && !r_empty;
  assign w_wr_en = w_push && (!r_full || w_rd_en);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == '0);
      r_full      <= (w_count_nxt == c_DEPTH);
      r_overflow  <= w_push && !w_wr_en;
      r_frame_err <= w_ferr;
    end
  end

  assign msg       = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_dbg_rx.sv
// ============================================================================
// Module      : tb_uart_dbg_rx
// Description : Directed, self-checking bench for the UART receiver and queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_dbg_rx;

  localparam int c_BIT = 104;
  // Edges from start-bit drive to stop-bit sample: 2 sync + 1 detect + 52 + 9*104
  localparam int c_LAT = 991;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] msg;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       frame_err;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;
  int long_cnt = 0;
  int fall_cyc = 0;
  int ferr_cyc = 0;
  logic prev_empty = 1'b1;
  logic prev_ovf = 1'b0;
  logic prev_ferr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic [7:0] exp_msg;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  uart_dbg_rx #(
    .SYS_CLK_FREQ  (12_000_000),
    .BAUD_RATE     (115_200),
    .MSG_QUEUE_SIZE(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rd       (rd),
    .msg      (msg),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if ((overflow && prev_ovf) || (frame_err && prev_ferr)) long_cnt++;
    if (prev_empty && !empty) fall_cyc = cyc;
    prev_empty = empty;
    prev_ovf   = overflow;
    prev_ferr  = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_cyc(c_BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(c_BIT);
    end
    rx = stop;
    wait_cyc(c_BIT);
    rx = 1'b1;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, 32'(msg), 32'(exp));
    rd = 1'b1;
    wait_cyc(1);
    rd = 1'b0;
  endtask

  initial begin
    int c0;
    int ovf0;
    int ferr0;

    tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_empty: 1'b0, exp_msg: 8'hA5, exp_ferr: 0};
    tbl[1] = '{data: 8'h00, stop: 1'b1, exp_empty: 1'b0, exp_msg: 8'h00, exp_ferr: 0};
    tbl[2] = '{data: 8'hFF, stop: 1'b1, exp_empty: 1'b0, exp_msg: 8'hFF, exp_ferr: 0};
    tbl[3] = '{data: 8'h3C, stop: 1'b0, exp_empty: 1'b1, exp_msg: 8'h00, exp_ferr: 1};
    tbl[4] = '{data: 8'h81, stop: 1'b1, exp_empty: 1'b0, exp_msg: 8'h81, exp_ferr: 0};
    tbl[5] = '{data: 8'h7E, stop: 1'b1, exp_empty: 1'b0, exp_msg: 8'h7E, exp_ferr: 0};

    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_msg", 32'(msg), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);

    for (int v = 0; v < 6; v++) begin
      ovf0  = ovf_cnt;
      ferr0 = ferr_cnt;
      c0    = cyc;
      send(tbl[v].data, tbl[v].stop);
      wait_cyc(4);
      chk($sformatf("vec%0d_empty", v), 32'(empty), 32'(tbl[v].exp_empty));
      chk($sformatf("vec%0d_msg", v), 32'(msg), 32'(tbl[v].exp_msg));
      chk($sformatf("vec%0d_frame_err", v), 32'(ferr_cnt - ferr0), 32'(tbl[v].exp_ferr));
      chk($sformatf("vec%0d_overflow", v), 32'(ovf_cnt - ovf0), 32'd0);
      if (tbl[v].exp_empty) begin
        chk($sformatf("vec%0d_ferr_latency", v), 32'(ferr_cyc - c0), 32'(c_LAT));
      end else begin
        chk($sformatf("vec%0d_empty_latency", v), 32'(fall_cyc - c0), 32'(c_LAT));
        pop_chk($sformatf("vec%0d_pop", v), tbl[v].exp_msg);
        chk($sformatf("vec%0d_drained", v), 32'(empty), 32'd1);
      end
      wait_cyc(10);
    end

    // Short low pulse must be rejected as a false start
    ferr0 = ferr_cnt;
    rx = 1'b0;
    wait_cyc(30);
    rx = 1'b1;
    wait_cyc(200);
    chk("glitch_empty", 32'(empty), 32'd1);
    chk("glitch_frame_err", 32'(ferr_cnt - ferr0), 32'd0);

    // Nine back-to-back frames into an 8-deep queue
    ovf0 = ovf_cnt;
    for (int b = 1; b <= 8; b++) send(8'(b), 1'b1);
    chk("fill8_full", 32'(full), 32'd1);
    chk("fill8_empty", 32'(empty), 32'd0);
    chk("fill8_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    send(8'h09, 1'b1);
    wait_cyc(4);
    chk("fill9_ovf", 32'(ovf_cnt - ovf0), 32'd1);
    chk("fill9_full", 32'(full), 32'd1);
    for (int b = 1; b <= 8; b++) pop_chk($sformatf("drain_a%0d", b), 8'(b));
    chk("drain_a_empty", 32'(empty), 32'd1);
    chk("drain_a_full", 32'(full), 32'd0);
    wait_cyc(10);

    // Ninth frame's stop sample coincides with a pop while full
    for (int b = 1; b <= 8; b++) send(8'(b), 1'b1);
    ovf0 = ovf_cnt;
    fork
      send(8'h09, 1'b1);
      begin
        wait_cyc(c_LAT - 1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
      end
    join
    wait_cyc(4);
    chk("coinc_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    chk("coinc_full", 32'(full), 32'd1);
    for (int b = 2; b <= 9; b++) pop_chk($sformatf("drain_b%0d", b), 8'(b));
    chk("drain_b_empty", 32'(empty), 32'd1);
    wait_cyc(10);

    // Reset during data bit 3 of 8'hFF with two bytes queued
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wait_cyc(4);
    chk("prereset_msg", 32'(msg), 32'h11);
    fork
      send(8'hFF, 1'b1);
      begin
        wait_cyc(470);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        chk("midreset_empty", 32'(empty), 32'd1);
        chk("midreset_msg", 32'(msg), 32'd0);
        chk("midreset_full", 32'(full), 32'd0);
      end
    join
    wait_cyc(10);
    chk("postreset_empty", 32'(empty), 32'd1);
    send(8'h5A, 1'b1);
    wait_cyc(4);
    chk("postreset_rx_empty", 32'(empty), 32'd0);
    pop_chk("postreset_rx_msg", 8'h5A);
    chk("postreset_drained", 32'(empty), 32'd1);

    chk("pulse_width", 32'(long_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
